rotation_decoder: RTL and testbench
===================================

Name: rotation_decoder

Overview:
- Inverse companion to the team's 8-bit rotator unit: given an original word and a rotated word, finds the rotation amount that maps one to the other.
- Sequential search: rotates an internal copy of the original one position per cycle and compares it against the captured rotated word.
- Sits on the checker/receive side of rotator datapaths. Recovers the rotation count for alignment, or flags the pair as not related by rotation.

Parameters:
- WIDTH, 8, data word width in bits; must be a power of 2 and at least 2.
- CNT_W, $clog2(WIDTH), width of the rotation-amount output.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a search; sampled only in IDLE.
- ref_in  input  WIDTH  original (unrotated) word; captured when start is accepted.
- rot_in  input  WIDTH  rotated word; captured when start is accepted.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- found  output  1  1 = a matching rotation exists; held until the next accepted start.
- amount  output  CNT_W  rotation step count; held until the next accepted start.
- dir_out  output  1  0 = left rotation, 1 = right rotation; held until the next accepted start.

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset: state IDLE; busy=0, done=0, found=0, amount=0, dir_out=0; internal candidate, target and counter registers cleared.
- Reset mid-search aborts the search immediately. No done pulse is produced and all outputs return to their reset values.
- States: IDLE, SEARCH.
- IDLE, start=1 at edge E0:
  - cand<=ref_in, tgt<=rot_in, cnt<=0, busy<=1, state<=SEARCH.
  - found/amount/dir_out clear to 0 at the same edge.
- SEARCH, each cycle:
  - If cand==tgt: at the next edge, found<=1, amount<=cnt, dir_out<=0, done<=1, busy<=0, state<=IDLE.
  - Else if cnt==WIDTH-1: at the next edge, found<=0, amount<=0, done<=1, busy<=0, state<=IDLE.
  - Else: cand<=rotate-left-by-1(cand), i.e. {cand[WIDTH-2:0],cand[WIDTH-1]}, and cnt<=cnt+1.
- Match at left rotation k asserts done at edge E(k+1), k+1 cycles after the start edge. A no-match result asserts done at edge E(WIDTH).
- Minimal k is always reported. For ref=0x00 or 0xFF, k=0.
- done is a single-cycle pulse; it is deasserted on the edge following its assertion.
- start while busy is ignored, with no effect on the search in progress.
- start in the same cycle done is asserted: state is already IDLE at that edge, so start is accepted on the next sampled edge only if still held.
- cnt never exceeds WIDTH-1 and does not wrap.

Optional Feature:
- Macro: ROTDEC_BIDIR_EN.
- With the macro defined:
  - A second candidate candr, loaded with ref_in at start, rotates right by 1 each cycle alongside cand.
  - Each cycle, cand==tgt is checked first; on a hit, dir_out<=0.
  - Otherwise candr==tgt is checked; on a hit, dir_out<=1.
  - amount<=cnt on either hit.
  - The search terminates with no match when cnt==WIDTH/2. No-match done therefore arrives at edge E(WIDTH/2+1).
  - Ties (k == WIDTH-k) report left.
- Without the macro:
  - Only the left search is built.
  - dir_out is constant 0.
  - Latency is as specified under Behaviour.

Test Plan:
- Reset, then start with ref=0xA5 and rot=0xA5 -> done at E1, found=1, amount=0, busy low from E1.
- ref=0x81, rot=0x0C (left by 3) -> done at E4, found=1, amount=3, dir_out=0.
- ref=0x01, rot=0x03 -> done at E8, found=0, amount=0. Bidir build: done at E5.
- Bidir build only: ref=0x01, rot=0x40 -> found=1, amount=2, dir_out=1. Default build: amount=6, dir_out=0.
- start pulsed again at E2 during the search for ref=0x81, rot=0x0C -> ignored; result unchanged (amount=3 at E4).
- rst_n=0 at E2 of a search -> next cycle busy=0, done=0, found=0. No done pulse follows, and a new start is then accepted normally.

Source files
------------

// File: rtl/rotation_decoder.sv
// rotation_decoder: sequential search for the rotation amount mapping ref_in to rot_in.
// Define ROTDEC_BIDIR_EN to search left and right rotations in parallel (halves no-match latency).
module rotation_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ref_in,
  input  logic [WIDTH-1:0] rot_in,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [CNT_W-1:0] amount,
  output logic             dir_out
);
  typedef enum logic {IDLE, SEARCH} state_t;
  state_t state;
  logic [WIDTH-1:0] cand, tgt;
  logic [CNT_W-1:0] cnt;
  logic hit_l, hit_r, hit;
`ifdef ROTDEC_BIDIR_EN
  // candr walks right while cand walks left; both directions meet at WIDTH/2
  logic [WIDTH-1:0] candr;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2);
  assign hit_r = candr == tgt;
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  assign hit_r = 1'b0;
`endif
  assign hit_l = cand == tgt;
  assign hit = hit_l || hit_r;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cand    <= '0;
      tgt     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      amount  <= '0;
      dir_out <= 1'b0;
`ifdef ROTDEC_BIDIR_EN
      candr   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          cand    <= ref_in;
          tgt     <= rot_in;
          cnt     <= '0;
          busy    <= 1'b1;
          found   <= 1'b0;
          amount  <= '0;
          dir_out <= 1'b0;
          state   <= SEARCH;
`ifdef ROTDEC_BIDIR_EN
          candr   <= ref_in;
`endif
        end
      end else if (hit || cnt == LAST) begin
        found   <= hit;
        amount  <= hit ? cnt : '0;
        dir_out <= !hit_l && hit_r;
        done    <= 1'b1;
        busy    <= 1'b0;
        state   <= IDLE;
      end else begin
        cand  <= {cand[WIDTH-2:0], cand[WIDTH-1]};
        cnt   <= cnt + 1'b1;
`ifdef ROTDEC_BIDIR_EN
        candr <= {candr[0], candr[WIDTH-1:1]};
`endif
      end
    end
  end
endmodule

// File: tb/tb_rotation_decoder.sv
// tb_rotation_decoder: directed table of searches plus start-while-busy and mid-search reset sequences.
module tb_rotation_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ref_in = '0;
  logic [7:0] rot_in = '0;
  logic       busy, done, found, dir_out;
  logic [2:0] amount;
  int total = 0;
  int bad = 0;

  rotation_decoder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ref_in(ref_in), .rot_in(rot_in),
    .busy(busy), .done(done), .found(found), .amount(amount), .dir_out(dir_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] t;
    logic       f;
    int         amt;
    logic       d;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Launch a search; optionally re-pulse start (with different data) just before E2.
  task automatic run(input vec_t v, input bit poke, input string tag);
    int lat;
    @(negedge clk);
    start = 1'b1; ref_in = v.r; rot_in = v.t;
    @(posedge clk); #1;
    chk({tag, " busy@E0"}, busy, 1);
    chk({tag, " found cleared@E0"}, found, 0);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    while (1) begin
      if (poke && lat == 1) begin
        @(negedge clk);
        start = 1'b1; ref_in = 8'h01; rot_in = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done || lat > 20) break;
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " found"}, found, v.f);
    chk({tag, " amount"}, amount, v.amt);
    chk({tag, " dir"}, dir_out, v.d);
    chk({tag, " busy@done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " amount held"}, amount, v.amt);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 1, 0, 0, 1};
    tbl[1] = '{8'h81, 8'h0C, 1, 3, 0, 4};
    tbl[2] = '{8'h00, 8'h00, 1, 0, 0, 1};
    tbl[3] = '{8'hFF, 8'hFF, 1, 0, 0, 1};
    tbl[4] = '{8'h12, 8'h24, 1, 1, 0, 2};
    tbl[5] = '{8'hF0, 8'h0F, 1, 4, 0, 5};
    tbl[6] = '{8'hAA, 8'h55, 1, 1, 0, 2};
`ifdef ROTDEC_BIDIR_EN
    tbl[7] = '{8'h01, 8'h03, 0, 0, 0, 5};
    tbl[8] = '{8'h01, 8'h40, 1, 2, 1, 3};
`else
    tbl[7] = '{8'h01, 8'h03, 0, 0, 0, 8};
    tbl[8] = '{8'h01, 8'h40, 1, 6, 0, 7};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset found", found, 0);
    chk("reset amount", amount, 0);
    chk("reset dir", dir_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run(tbl[i], 1'b0, $sformatf("vec%0d", i));
    run(tbl[1], 1'b1, "start_while_busy");
    // reset asserted so that E2 of a search samples rst_n=0
    begin
      int seen;
      @(negedge clk);
      start = 1'b1; ref_in = 8'h01; rot_in = 8'h03;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst found", found, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      chk("no done after reset", seen, 0);
    end
    run(tbl[1], 1'b0, "after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
